// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war match logic: phase encoding, tally/level
// widths and the pacing-period helper used by the match controller.
package tow_pkg;

   localparam int TALLY_W = 4;
   localparam int LEVEL_W = 3;

   typedef enum logic [2:0] {
      PH_IDLE   = 3'd0,
      PH_ARM    = 3'd1,
      PH_PLAY   = 3'd2,
      PH_RESULT = 3'd3,
      PH_DONE   = 3'd4
   } phase_t;

   function automatic int pace_period(input int base_div, input int step_div,
                                      input logic [LEVEL_W-1:0] lvl);
      return base_div - int'(lvl) * step_div;
   endfunction

endpackage

// File: rtl/tow_match_ctrl_pace_divider.sv
// Loadable pacing down-counter: reloads to period-1 on load or on reaching zero,
// and flags expiry while the count sits at zero.
module pace_divider #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] period,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load || (en && cnt_q == '0)) begin
         cnt_d = period - W'(1);
      end else if (en) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = (cnt_q == '0);

endmodule

// File: rtl/tow_match_ctrl.sv
// Best-of-N match sequencer and speed-scaled pacing strobe for the tug-of-war game.
// state  | meaning
// IDLE   | waiting for start after reset
// ARM    | lead-in of ARM_TICKS pacing periods before the round
// PLAY   | round live, slowen pulses, waiting for winrnd
// RESULT | post-round hold of RESULT_HOLD cycles
// DONE   | match decided, tallies held until start
module tow_match_ctrl
   import tow_pkg::*;
#(
   parameter int BASE_DIV         = 256,
   parameter int STEP_DIV         = 32,
   parameter int MAX_LEVEL        = 7,
   parameter int ROUNDS_PER_LEVEL = 2,
   parameter int WIN_ROUNDS       = 3,
   parameter int ARM_TICKS        = 4,
   parameter int RESULT_HOLD      = 512
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               winrnd,
   input  logic               right,
   input  logic               tie,
   output logic               slowen,
   output logic [LEVEL_W-1:0] level,
   output logic [TALLY_W-1:0] rounds_r,
   output logic [TALLY_W-1:0] rounds_l,
   output logic [2:0]         phase,
   output logic               match_over,
   output logic               match_winner
);

   localparam int PW = $clog2(BASE_DIV + 1);
   localparam int HW = $clog2(RESULT_HOLD + 1);
   localparam int AW = $clog2(ARM_TICKS + 1);
   localparam int DW = $clog2(ROUNDS_PER_LEVEL + 1);

   if (BASE_DIV - MAX_LEVEL * STEP_DIV < 2) begin : g_bad_div
      $error("tow_match_ctrl: fastest pacing period must be at least 2 cycles");
   end
   if (WIN_ROUNDS < 1 || WIN_ROUNDS > 15) begin : g_bad_win
      $error("tow_match_ctrl: WIN_ROUNDS must be within 1..15");
   end

   phase_t             phase_q, phase_d;
   logic [TALLY_W-1:0] rr_q, rr_d, rl_q, rl_d;
   logic [LEVEL_W-1:0] level_q, level_d;
   logic [DW-1:0]      dec_q, dec_d;
   logic [AW-1:0]      arm_q, arm_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic               winner_q, winner_d;
   logic               div_load, div_en, expire;
   logic [PW-1:0]      period;

   always_comb begin
      phase_d  = phase_q;
      rr_d     = rr_q;
      rl_d     = rl_q;
      level_d  = level_q;
      dec_d    = dec_q;
      arm_d    = arm_q;
      hold_d   = hold_q;
      winner_d = winner_q;
      div_load = 1'b0;
      unique case (phase_q)
         PH_IDLE, PH_DONE: begin
            if (start) begin
               phase_d  = PH_ARM;
               rr_d     = '0;
               rl_d     = '0;
               level_d  = '0;
               dec_d    = '0;
               winner_d = 1'b0;
               arm_d    = AW'(ARM_TICKS - 1);
               div_load = 1'b1;
            end
         end
         PH_ARM: begin
            if (expire) begin
               if (arm_q == '0) begin
                  phase_d  = PH_PLAY;
                  div_load = 1'b1;
               end else begin
                  arm_d = arm_q - AW'(1);
               end
            end
         end
         PH_PLAY: begin
            if (winrnd) begin
               phase_d = PH_RESULT;
               hold_d  = HW'(RESULT_HOLD - 1);
               if (!tie) begin
                  if (right) rr_d = rr_q + TALLY_W'(1);
                  else       rl_d = rl_q + TALLY_W'(1);
                  if (dec_q == DW'(ROUNDS_PER_LEVEL - 1)) begin
                     dec_d = '0;
                     if (level_q != LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
                  end else begin
                     dec_d = dec_q + DW'(1);
                  end
                  if ((right ? rr_d : rl_d) == TALLY_W'(WIN_ROUNDS)) begin
                     phase_d  = PH_DONE;
                     winner_d = right;
                  end
               end
            end
         end
         PH_RESULT: begin
            if (hold_q == '0) begin
               phase_d  = PH_ARM;
               arm_d    = AW'(ARM_TICKS - 1);
               div_load = 1'b1;
            end else begin
               hold_d = hold_q - HW'(1);
            end
         end
         default: phase_d = PH_IDLE;
      endcase
   end

   // Reloads take the post-update level so a new period applies from ARM entry.
   assign period = PW'(pace_period(BASE_DIV, STEP_DIV, level_d));
   assign div_en = (phase_q == PH_ARM) || (phase_q == PH_PLAY);

   pace_divider #(.W(PW)) u_pace (
      .clk    (clk),
      .rst    (rst),
      .load   (div_load),
      .en     (div_en),
      .period (period),
      .expire (expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_q  <= PH_IDLE;
         rr_q     <= '0;
         rl_q     <= '0;
         level_q  <= '0;
         dec_q    <= '0;
         arm_q    <= '0;
         hold_q   <= '0;
         winner_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         rr_q     <= rr_d;
         rl_q     <= rl_d;
         level_q  <= level_d;
         dec_q    <= dec_d;
         arm_q    <= arm_d;
         hold_q   <= hold_d;
         winner_q <= winner_d;
      end
   end

   assign slowen       = (phase_q == PH_PLAY) && expire;
   assign level        = level_q;
   assign rounds_r     = rr_q;
   assign rounds_l     = rl_q;
   assign phase        = phase_q;
   assign match_over   = (phase_q == PH_DONE);
   assign match_winner = winner_q;

endmodule
